// File: rtl/parameters_pkg.sv
// Field constants, exponent and encoder state type for the Ed448 point encoder.
package parameters_pkg;

  localparam int DATA_WIDTH = 449;
  localparam int ENC_WIDTH  = 456;
  localparam int MUL_OPS    = 896;
  localparam int T_MUL      = 3;

  // p = 2^448 - 2^224 - 1
  localparam logic [DATA_WIDTH-1:0] P_MOD = {1'b0, {223{1'b1}}, 1'b0, {224{1'b1}}};
  // R = 2^448, so R mod p = 2^224 + 1
  localparam logic [DATA_WIDTH-1:0] R_MOD_P = (449'd1 << 224) + 449'd1;
  localparam logic [447:0] P_MINUS_2 = {{223{1'b1}}, 1'b0, {222{1'b1}}, 1'b0, 1'b1};
  // -p^-1 mod 2^448 = 2^448 - 2^224 + 1
  localparam logic [447:0] N_PRIME = {{224{1'b1}}, {223{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    INV,
    MUL_X,
    MUL_Y,
    CONV_X,
    CONV_Y,
    PACK
  } state_t;

endpackage

// File: rtl/mont_mul.sv
// Three-stage Montgomery multiplier, R = 2^448; result is left in [0, 2p).
module mont_mul
  import parameters_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]         prod_reg;
  logic [PW-1:0]         prod2_reg;
  logic [447:0]          m_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic                  v1_reg;
  logic                  v2_reg;
  logic                  done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_reg   <= '0;
      prod2_reg  <= '0;
      m_reg      <= '0;
      result_reg <= '0;
      v1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      v1_reg   <= start;
      v2_reg   <= v1_reg;
      done_reg <= v2_reg;
      if (start) prod_reg <= PW'(a) * PW'(b);
      if (v1_reg) begin
        m_reg     <= 448'(prod_reg) * N_PRIME;
        prod2_reg <= prod_reg;
      end
      // Low 448 bits of the sum are zero by construction of m
      if (v2_reg) result_reg <= DATA_WIDTH'((prod2_reg + PW'(m_reg) * PW'(P_MOD)) >> 448);
    end
  end

  assign result = result_reg;
  assign done   = done_reg;

endmodule

// File: rtl/point_encode.sv
// Projective Ed448 point (Montgomery domain) to 57-byte encoding via Fermat inversion.
// Optional Z==0 early exit is enabled by defining POINT_ENC_ZCHK_EN.
module point_encode
  import parameters_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] X,
  input  logic [DATA_WIDTH-1:0] Y,
  input  logic [DATA_WIDTH-1:0] Z,
  output logic [ENC_WIDTH-1:0]  enc_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t                state_reg, state_next;
  logic [8:0]            idx_reg, idx_next;
  logic                  phase_reg, phase_next;   // 1: multiply-by-Z pending for this bit
  logic                  issue_reg, issue_next;
  logic [DATA_WIDTH-1:0] x_reg, y_reg, z_reg, acc_reg;
  logic                  busy_reg, done_reg;
  logic [ENC_WIDTH-1:0]  enc_reg;
  logic [ENC_WIDTH-1:0]  pack_val;
  logic [DATA_WIDTH-1:0] op_a, op_b, mul_res, mul_red;
  logic                  mul_done;
  logic                  accept;

  // busy still covers the done cycle, so a restart lands one cycle later
  assign accept = (state_reg == IDLE) && start && !busy_reg;

  mont_mul u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (issue_reg),
    .a      (op_a),
    .b      (op_b),
    .result (mul_res),
    .done   (mul_done)
  );

  assign mul_red = (mul_res >= P_MOD) ? (mul_res - P_MOD) : mul_res;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    phase_next = phase_reg;
    issue_next = 1'b0;
    op_a       = acc_reg;
    op_b       = acc_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          idx_next   = 9'd446;
          phase_next = 1'b0;
`ifdef POINT_ENC_ZCHK_EN
          if (Z == '0) begin
            state_next = PACK;
          end else begin
            state_next = INV;
            issue_next = 1'b1;
          end
`else
          state_next = INV;
          issue_next = 1'b1;
`endif
        end
      end
      INV: begin
        op_b = phase_reg ? z_reg : acc_reg;
        if (mul_done) begin
          issue_next = 1'b1;
          if (!phase_reg && P_MINUS_2[idx_reg]) begin
            phase_next = 1'b1;
          end else begin
            phase_next = 1'b0;
            if (idx_reg == 9'd0) state_next = MUL_X;
            else                 idx_next   = idx_reg - 9'd1;
          end
        end
      end
      MUL_X: begin
        op_a = x_reg;
        if (mul_done) begin
          state_next = MUL_Y;
          issue_next = 1'b1;
        end
      end
      MUL_Y: begin
        op_a = y_reg;
        if (mul_done) begin
          state_next = CONV_X;
          issue_next = 1'b1;
        end
      end
      CONV_X: begin
        op_a = x_reg;
        op_b = DATA_WIDTH'(1);
        if (mul_done) begin
          state_next = CONV_Y;
          issue_next = 1'b1;
        end
      end
      CONV_Y: begin
        op_a = y_reg;
        op_b = DATA_WIDTH'(1);
        if (mul_done) state_next = PACK;
      end
      PACK:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      phase_reg <= 1'b0;
      issue_reg <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      acc_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      enc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      phase_reg <= phase_next;
      issue_reg <= issue_next;
      done_reg  <= (state_reg == PACK);
      if (accept) begin
        x_reg    <= X;
        y_reg    <= Y;
        z_reg    <= Z;
        acc_reg  <= Z;
        busy_reg <= 1'b1;
      end else if (done_reg) begin
        busy_reg <= 1'b0;
      end
      if (mul_done) begin
        case (state_reg)
          INV:           acc_reg <= mul_red;
          MUL_X, CONV_X: x_reg   <= mul_red;
          MUL_Y, CONV_Y: y_reg   <= mul_red;
          default:       ;
        endcase
      end
      if (state_reg == PACK) enc_reg <= pack_val;
    end
  end

`ifdef POINT_ENC_ZCHK_EN
  logic zero_reg;
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      if (accept) zero_reg <= (Z == '0);
      if (state_reg == PACK) err_reg <= zero_reg;
    end
  end

  assign pack_val = zero_reg ? '0 : {x_reg[0], 7'b0, y_reg[447:0]};
  assign err      = err_reg;
`else
  assign pack_val = {x_reg[0], 7'b0, y_reg[447:0]};
  assign err      = 1'b0;
`endif

  assign enc_out = enc_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_point_encode.sv
// Scoreboard bench for point_encode; expected encodings come from plain (non-Montgomery) modular arithmetic.
`timescale 1ns/1ps
module tb_point_encode;
  import parameters_pkg::*;

  typedef struct {
    logic [455:0] enc;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  localparam logic [897:0] PB       = (898'd1 << 448) - (898'd1 << 224) - 898'd1;
  localparam logic [447:0] EXP_INV  = 448'(PB - 898'd2);
  localparam int           FULL_LAT = MUL_OPS * (T_MUL + 1) + 2;
  localparam logic [447:0] GX = 448'h4f1970c66bed0ded221d15a622bf36da9e146570470f1767ea6de324a3d3a46412ae1af72ab66511433b80e18b00938e2626a82bc70cc05e;
  localparam logic [447:0] GY = 448'h693f46716eb6bc248876203756c9c7624bea73736ca3984087789c1e05a0c2d73ad3ff1ce67c39c4fdbd132c4ed7c8ad9808795bf230fa14;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [DATA_WIDTH-1:0] x_in, y_in, z_in;
  logic [455:0]          enc_out;
  logic                  busy, done, err;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  logic [447:0] r_mont;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  point_encode dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .X       (x_in),
    .Y       (y_in),
    .Z       (z_in),
    .enc_out (enc_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic check_val(input string tag, input logic [459:0] got, input logic [459:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [447:0] fmod(input logic [897:0] v);
    return 448'(v % PB);
  endfunction

  function automatic logic [447:0] fmul(input logic [447:0] a, input logic [447:0] b);
    return fmod(898'(a) * 898'(b));
  endfunction

  function automatic logic [447:0] fpow(input logic [447:0] base, input logic [447:0] e);
    logic [447:0] r, b;
    r = 448'd1;
    b = base;
    for (int i = 0; i < 448; i++) begin
      if (e[i]) r = fmul(r, b);
      b = fmul(b, b);
    end
    return r;
  endfunction

  function automatic logic [455:0] expect_enc(input logic [447:0] xm, input logic [447:0] ym, input logic [447:0] zm);
    logic [447:0] zi, xa, ya;
    zi = fpow(zm, EXP_INV);
    xa = fmul(xm, zi);
    ya = fmul(ym, zi);
    return {xa[0], 7'b0, ya};
  endfunction

  function automatic logic [447:0] rand_fe();
    logic [447:0] v;
    for (int i = 0; i < 14; i++) v[i*32 +: 32] = $urandom;
    return fmod(898'(v));
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", 460'(done), 460'd0);
      end else begin
        e = sb.pop_front();
        check_val("enc_out", 460'(enc_out), 460'(e.enc));
        check_val("err", 460'(err), 460'(e.err));
        check_val("latency", 460'(cyc - e.t0), 460'(e.lat));
        check_val("busy_at_done", 460'(busy), 460'd1);
        $display("txn enc=%0h err=%0d latency=%0d", enc_out, err, cyc - e.t0);
      end
    end
  end

  task automatic launch(input logic [447:0] xv, input logic [447:0] yv, input logic [447:0] zv,
                        input logic [455:0] enc, input logic e, input int lat);
    exp_t item;
    @(negedge clk);
    x_in  = DATA_WIDTH'(xv);
    y_in  = DATA_WIDTH'(yv);
    z_in  = DATA_WIDTH'(zv);
    start = 1'b1;
    item.enc = enc;
    item.err = e;
    item.lat = lat;
    item.t0  = cyc;
    sb.push_back(item);
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", 460'(busy), 460'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 460'(sb.size()), 460'd0);
    if (sb.size() != 0) sb.delete();
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("done_seen", 460'(done), 460'd1);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [447:0] m5, km, gxm, gym, ax, ay, az, bx, by, bz, rr;
    logic [455:0] enc_a;
    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    z_in  = '0;
    r_mont = fmod(898'd1 << 448);
    repeat (3) @(negedge clk);
    check_val("reset_state", {enc_out, busy, done, err, 1'b0}, '0);
    rst_n = 1'b1;

    // identity point
    launch(448'd0, r_mont, r_mont, 456'h1, 1'b0, FULL_LAT);
    wait_idle(FULL_LAT + 50);

    // X = Y = Z = Montgomery(5)
    m5 = fmul(448'd5, r_mont);
    launch(m5, m5, m5, {1'b1, 7'b0, 448'd1}, 1'b0, FULL_LAT);
    wait_idle(FULL_LAT + 50);

    // base point scaled by k = 7
    km  = fmul(448'd7, r_mont);
    gxm = fmul(fmul(GX, r_mont), 448'd7);
    gym = fmul(fmul(GY, r_mont), 448'd7);
    launch(gxm, gym, km, expect_enc(gxm, gym, km), 1'b0, FULL_LAT);
    wait_idle(FULL_LAT + 50);

    // random projective inputs
    for (int t = 0; t < 2; t++) begin
      ax = rand_fe();
      ay = rand_fe();
      az = rand_fe();
      launch(ax, ay, az, expect_enc(ax, ay, az), 1'b0, FULL_LAT);
      wait_idle(FULL_LAT + 50);
    end

    // start while busy is ignored; start right after done is accepted
    ax = rand_fe();
    ay = rand_fe();
    az = rand_fe();
    enc_a = expect_enc(ax, ay, az);
    launch(ax, ay, az, enc_a, 1'b0, FULL_LAT);
    repeat (100) @(negedge clk);
    x_in  = DATA_WIDTH'(rand_fe());
    z_in  = DATA_WIDTH'(rand_fe());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_mid_inv", 460'(busy), 460'd1);
    wait_done(FULL_LAT + 50);
    bx = rand_fe();
    by = rand_fe();
    bz = rand_fe();
    launch(bx, by, bz, expect_enc(bx, by, bz), 1'b0, FULL_LAT);
    wait_idle(FULL_LAT + 50);

    // reset mid-inversion discards the run
    launch(bx, ay, az, expect_enc(bx, ay, az), 1'b0, FULL_LAT);
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_val("reset_mid_inv", {enc_out, busy, done, err, 1'b0}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    rr = rand_fe();
    launch(ay, rr, bz, expect_enc(ay, rr, bz), 1'b0, FULL_LAT);
    wait_idle(FULL_LAT + 50);

    // Z = 0
`ifdef POINT_ENC_ZCHK_EN
    launch(r_mont, r_mont, 448'd0, 456'd0, 1'b1, 2);
`else
    launch(r_mont, r_mont, 448'd0, expect_enc(r_mont, r_mont, 448'd0), 1'b0, FULL_LAT);
`endif
    wait_idle(FULL_LAT + 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/point_encode.md
# point_encode

Converts a projective Ed448 point (X:Y:Z), Montgomery domain, as produced by the scalar-multiplication ladder into the 57-byte RFC 8032 point encoding. It computes Z⁻¹ by Fermat exponentiation (Z^(p−2)) on one shared Montgomery multiplier. It then forms affine x and y, leaves the Montgomery domain, reduces both to canonical form, and packs the result. It sits downstream of the ladder in the signing and public-key paths.

## Interface
- DATA_WIDTH, from parameters_pkg: field word width in bits (≥ 449).
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: single-cycle request; sampled only in IDLE.
- X, Y, Z  in  DATA_WIDTH each: projective point, Montgomery domain; captured on the accepted start.
- enc_out  out  456: encoded point; held from done until the next accepted start.
- busy  out  1: high from the cycle after an accepted start through the done cycle.
- done  out  1: one-cycle pulse when enc_out is valid.
- err  out  1: Z==0 flag, valid with done (see Configuration).

## Operation
- States: IDLE → INV (square/multiply loop) → MUL_X → MUL_Y → CONV_X → CONV_Y → PACK → IDLE.
- IDLE, start=1:
  - capture X, Y, Z into registers;
  - acc ← Z (this is exponent bit 447, always 1);
  - bit index i ← 446;
  - go to INV.
- INV, for i = 446 down to 0:
  - acc ← mont_mul(acc, acc);
  - if P_MINUS_2[i] = 1, then acc ← mont_mul(acc, Zreg).
  - Fixed schedule: 447 squarings + 445 multiplies. popcount(p−2) = 446.
- MUL_X: xm ← mont_mul(Xreg, acc). MUL_Y: ym ← mont_mul(Yreg, acc).
- CONV_X: x ← mont_mul(xm, 1). CONV_Y: y ← mont_mul(ym, 1).
  - Each multiplier result in [p, 2p) has p subtracted once, so x, y < p.
- PACK:
  - enc_out[447:0] ← y;
  - enc_out[454:448] ← 0;
  - enc_out[455] ← x[0];
  - done ← 1 for one cycle.
- start while busy is ignored; the running computation is unaffected.
- Multiplier handshake: one-cycle start pulse, then wait for its done. The result is captured in the done cycle, and the next operation is issued in the following cycle.

## Timing
- Reset values: enc_out = 0, done = 0, busy = 0, err = 0, state = IDLE. The multiplier start is held low.
- Reset asserted mid-operation: the block returns to IDLE immediately; no done is produced and partial results are discarded.
- Total operations: 896 multiplier operations = 892 (inversion) + 4.
- Latency, accepted start to done: 896·(T_MUL+1) + 2 cycles. T_MUL is the multiplier's start-to-done latency.
- Latency is data-independent; there is no early exit except the Z==0 path below.
- A new start is accepted the cycle after done.

## Configuration
- POINT_ENC_ZCHK_EN defined:
  - Z == 0 is detected in the IDLE capture cycle;
  - the block skips INV through CONV and goes directly to PACK with enc_out = 0 and err = 1;
  - latency in this case is 2 cycles.
- POINT_ENC_ZCHK_EN undefined:
  - no detection; Z = 0 runs the full schedule (0^(p−2) = 0) and yields enc_out = 0;
  - err is tied to 0.

## Structure
- parameters_pkg gains:
  - P_MINUS_2 (448-bit exponent);
  - the state_t enum;
  - MUL_OPS = 896.
- P_MOD and R_MOD_P are reused from the same package.
- One sub-module: a single mont_mul instance (existing primitive), time-multiplexed.
- Operand multiplexing and the conditional subtract stay in this module.

## Test plan
- Identity: X = 0, Y = R_MOD_P, Z = R_MOD_P → enc_out = 456'h1; err = 0; latency exactly 896·(T_MUL+1)+2.
- Scaled point: X = Y = Z = Montgomery(5) → x = y = 1 → enc_out[455] = 1, enc_out[447:0] = 1, bits 454:448 = 0.
- Ed448 base point:
  - inputs: Montgomery(Gx)·k, Montgomery(Gy)·k, Montgomery(k) for k = 7;
  - required: enc_out equals the RFC 8032 generator encoding from the golden model.
  - Also run random ladder outputs against the golden model.
- Busy/restart:
  - start pulsed again mid-INV → ignored; one done with the first result;
  - start in the cycle after done → accepted.
- Reset mid-INV: rst_n low for 1 cycle → outputs return to reset values, no done; the next start completes normally.
- Z = 0 with X = Y = R_MOD_P:
  - macro on: done 2 cycles after start, err = 1, enc_out = 0;
  - macro off: full latency, enc_out = 0, err = 0.
